// File: rtl/nibble_alu_sequencer.sv
// rtl/nibble_alu_sequencer.sv - WIDTH-bit bitwise logic op sequenced through one external 4-bit AND slice
module nibble_alu_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [3:0]       slice_x,
   output logic [3:0]       slice_y,
   input  logic [3:0]       slice_f,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] f,
   output logic             zero,
   output logic             busy
);

   localparam int N  = WIDTH / 4;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [CW-1:0] LAST = CW'(N - 1);

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] x_reg;
   logic [WIDTH-1:0] y_reg;
   logic [1:0]       op_reg;
   logic [3:0]       nib_x;
   logic [3:0]       nib_y;
   logic [3:0]       res_nib;

   always_comb begin
      nib_x = '0;
      nib_y = '0;
      for (int i = 0; i < N; i++) begin
         if (cnt == CW'(i)) begin
            nib_x = x_reg[4*i +: 4];
            nib_y = y_reg[4*i +: 4];
         end
      end
   end

   // ANDN/NOR/NAND are all derived from one AND slice via De Morgan inversions.
   always_comb begin
      slice_x = '0;
      slice_y = '0;
      if (state == RUN) begin
         slice_x = (op_reg == 2'b11) ? ~nib_x : nib_x;
         slice_y = op_reg[0] ? ~nib_y : nib_y;
      end
   end

   assign res_nib   = (op_reg == 2'b10) ? ~slice_f : slice_f;
   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);
   assign zero      = ~|f;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         x_reg  <= '0;
         y_reg  <= '0;
         op_reg <= '0;
         f      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  x_reg  <= x;
                  y_reg  <= y;
                  op_reg <= op;
                  f      <= '0;
                  cnt    <= '0;
                  state  <= RUN;
               end
            end
            RUN: begin
               for (int i = 0; i < N; i++) begin
                  if (cnt == CW'(i)) begin
                     f[4*i +: 4] <= res_nib;
                  end
               end
               if (cnt == LAST) begin
                  state <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_alu_sequencer.sv
// tb/tb_nibble_alu_sequencer.sv - directed bench for nibble_alu_sequencer with a behavioural AND slice
module tb_nibble_alu_sequencer;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  op;
   logic [31:0] x;
   logic [31:0] y;
   logic [3:0]  slice_x;
   logic [3:0]  slice_y;
   logic [3:0]  slice_f;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] f;
   logic        zero;
   logic        busy;

   int tests_run;
   int tests_failed;
   int lat;
   logic [3:0] cap_x [8];
   logic [3:0] cap_y [8];

   nibble_alu_sequencer #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .x(x), .y(y), .slice_x(slice_x), .slice_y(slice_y), .slice_f(slice_f),
      .out_valid(out_valid), .out_ready(out_ready), .f(f), .zero(zero), .busy(busy)
   );

   assign slice_f = slice_x & slice_y;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Accepts one op, records per-cycle slice operands, returns edges from accept to out_valid.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
      x = a; y = b; op = o; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = -1;
      for (int c = 0; c < 20; c++) begin
         if (out_valid) begin
            lat = c;
            break;
         end
         if (c < 8) begin
            cap_x[c] = slice_x;
            cap_y[c] = slice_y;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      tests_run++; if (zero !== 1'b1) begin tests_failed++; $display("FAIL reset_zero got=%b exp=1", zero); end
      tests_run++; if (f !== 32'h0) begin tests_failed++; $display("FAIL reset_f got=%h exp=00000000", f); end
      tests_run++; if ({slice_x, slice_y} !== 8'h00) begin tests_failed++; $display("FAIL reset_slice got=%h exp=00", {slice_x, slice_y}); end
   endtask

   task automatic test_and();
      logic [3:0] ex [8];
      logic [3:0] ey [8];
      ex = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h0, 4'hF, 4'h0, 4'hF};
      ey = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'hF, 4'hF, 4'h0};
      issue(32'hF0F01234, 32'h0FF0FFFF, 2'b00);
      tests_run++; if (lat !== 8) begin tests_failed++; $display("FAIL and_latency got=%0d exp=8", lat); end
      for (int i = 0; i < 8; i++) begin
         tests_run++; if (cap_x[i] !== ex[i]) begin tests_failed++; $display("FAIL and_slice_x[%0d] got=%h exp=%h", i, cap_x[i], ex[i]); end
         tests_run++; if (cap_y[i] !== ey[i]) begin tests_failed++; $display("FAIL and_slice_y[%0d] got=%h exp=%h", i, cap_y[i], ey[i]); end
      end
      tests_run++; if (f !== 32'h00F01234) begin tests_failed++; $display("FAIL and_f got=%h exp=00F01234", f); end
      tests_run++; if (zero !== 1'b0) begin tests_failed++; $display("FAIL and_zero got=%b exp=0", zero); end
      tests_run++; if ({slice_x, slice_y} !== 8'h00) begin tests_failed++; $display("FAIL done_isolation got=%h exp=00", {slice_x, slice_y}); end
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL done_busy got=%b exp=1", busy); end
      release_result();
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL and_release_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_andn();
      logic [3:0] ey [8];
      ey = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF};
      issue(32'hF0F01234, 32'h0FF0FFFF, 2'b01);
      tests_run++; if (lat !== 8) begin tests_failed++; $display("FAIL andn_latency got=%0d exp=8", lat); end
      for (int i = 0; i < 8; i++) begin
         tests_run++; if (cap_y[i] !== ey[i]) begin tests_failed++; $display("FAIL andn_slice_y[%0d] got=%h exp=%h", i, cap_y[i], ey[i]); end
      end
      tests_run++; if (f !== 32'hF0000000) begin tests_failed++; $display("FAIL andn_f got=%h exp=F0000000", f); end
      release_result();
   endtask

   task automatic test_nand_zero();
      issue(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10);
      tests_run++; if (f !== 32'h00000000) begin tests_failed++; $display("FAIL nand_f got=%h exp=00000000", f); end
      tests_run++; if (zero !== 1'b1) begin tests_failed++; $display("FAIL nand_zero got=%b exp=1", zero); end
      release_result();
   endtask

   task automatic test_nor();
      issue(32'h0000000F, 32'h000000F0, 2'b11);
      tests_run++; if (f !== 32'hFFFFFF00) begin tests_failed++; $display("FAIL nor_f got=%h exp=FFFFFF00", f); end
      tests_run++; if (zero !== 1'b0) begin tests_failed++; $display("FAIL nor_zero got=%b exp=0", zero); end
      release_result();
   endtask

   task automatic test_backpressure();
      issue(32'h12345678, 32'h0F0F0F0F, 2'b00);
      tests_run++; if (lat !== 8) begin tests_failed++; $display("FAIL bp_latency got=%0d exp=8", lat); end
      for (int c = 0; c < 5; c++) begin
         in_valid = c[0] ? 1'b0 : 1'b1;
         x = 32'hFFFFFFFF; y = 32'hFFFFFFFF; op = 2'b10;
         @(posedge clk); #1;
         tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_out_valid[%0d] got=%b exp=1", c, out_valid); end
         tests_run++; if (f !== 32'h02040608) begin tests_failed++; $display("FAIL bp_f[%0d] got=%h exp=02040608", c, f); end
         tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", c, in_ready); end
      end
      in_valid = 1'b0;
      release_result();
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); end
      @(posedge clk); #1;
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL idle_no_accept_busy got=%b exp=0", busy); end
      tests_run++; if (f !== 32'h02040608) begin tests_failed++; $display("FAIL idle_f_retained got=%h exp=02040608", f); end
   endtask

   task automatic test_reset_mid_run();
      x = 32'hFFFFFFFF; y = 32'hFFFFFFFF; op = 2'b00; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      x = 32'h0; y = 32'h0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
      end
      tests_run++; if (f !== 32'h00000FFF) begin tests_failed++; $display("FAIL mid_partial_f got=%h exp=00000FFF", f); end
      tests_run++; if (slice_x !== 4'hF) begin tests_failed++; $display("FAIL mid_slice_x got=%h exp=F", slice_x); end
      #2 rst_n = 1'b0;
      #1;
      tests_run++; if (f !== 32'h0) begin tests_failed++; $display("FAIL rst_mid_f got=%h exp=00000000", f); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_out_valid got=%b exp=0", out_valid); end
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_in_ready got=%b exp=1", in_ready); end
      tests_run++; if (slice_x !== 4'h0) begin tests_failed++; $display("FAIL rst_mid_slice_x got=%h exp=0", slice_x); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      issue(32'h12345678, 32'hFFFF0000, 2'b00);
      tests_run++; if (lat !== 8) begin tests_failed++; $display("FAIL post_rst_latency got=%0d exp=8", lat); end
      tests_run++; if (f !== 32'h12340000) begin tests_failed++; $display("FAIL post_rst_f got=%h exp=12340000", f); end
      release_result();
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      op = 2'b00;
      x = '0;
      y = '0;
      #12;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_and();
      test_andn();
      test_nand_zero();
      test_nor();
      test_backpressure();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/nibble_alu_sequencer.md
# nibble_alu_sequencer

Multi-cycle controller that computes a WIDTH-bit bitwise logic operation by time-multiplexing one 4-bit AND slice, the same gate-level 4-bit `bitwiseand` unit used in the ALU datapath. Per operation it:
- captures operands through a valid/ready handshake;
- steps a nibble counter and drives the slice one nibble per cycle, with optional operand or result inversion;
- assembles the full result and holds it until the consumer accepts it.

It sits between the ALU's operand source and its result consumer.

## Interface
- WIDTH, 32: operand/result width in bits; must be a multiple of 4 and at least 4. N = WIDTH/4 nibbles.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/opcode presented.
- in_ready  out  1  sequencer can accept an operation.
- op  in  2  00 AND (x&y), 01 ANDN (x&~y), 10 NAND (~(x&y)), 11 NOR (~x&~y).
- x, y  in  WIDTH  operands; sampled only on the accept edge.
- slice_x, slice_y  out  4  operand nibbles to the external 4-bit AND slice.
- slice_f  in  4  slice result; combinational function of slice_x/slice_y.
- out_valid  out  1  result f is complete and stable.
- out_ready  in  1  consumer accepts the result.
- f  out  WIDTH  registered result.
- zero  out  1  f == 0; meaningful only while out_valid = 1.
- busy  out  1  high in RUN and DONE.

## Operation
- States: IDLE, RUN, DONE. Nibble counter cnt is ceil(log2(N)) bits wide, minimum 1 bit.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch x, y, op; clear f to 0; set cnt = 0; go to RUN.
- RUN, each cycle:
  - slice_x = x_reg[4*cnt +: 4], inverted when op = 11.
  - slice_y = y_reg[4*cnt +: 4], inverted when op = 01 or 11.
  - At the edge, f[4*cnt +: 4] <= slice_f, inverted when op = 10.
  - If cnt = N-1, go to DONE; otherwise cnt <= cnt + 1.
  - No wrap-around: cnt never exceeds N-1.
- DONE:
  - out_valid = 1. f and zero are held constant.
  - On out_ready, go to IDLE.
  - out_ready is ignored outside DONE.
- Operand isolation: slice_x and slice_y are 0 in IDLE and DONE.
- in_valid is ignored while busy. Operands are not re-sampled during RUN, so x/y may change freely after the accept edge.
- f retains the last result after returning to IDLE, until the next accept clears it.
- Reset (rst_n low, any state, including mid-RUN):
  - Immediately forces state IDLE, cnt 0, f 0, x_reg/y_reg/op_reg 0.
  - Resulting outputs: out_valid 0, busy 0, in_ready 1, zero 1, slice_x/slice_y 0.
  - Any in-flight operation is discarded with no partial result visible.

## Timing
- Edge E0 = accept edge. Edges E1..EN write nibbles 0..N-1. DONE (out_valid = 1) is entered at EN, i.e. latency N cycles after the accept edge (8 for WIDTH = 32).
- Result handshake: completes at the first edge in DONE with out_ready = 1. in_ready rises the following cycle. There is no combinational path from out_ready to in_ready.
- Minimum issue interval: N+2 cycles (1 IDLE + N RUN + 1 DONE).
- All outputs except slice_x/slice_y are registered or decoded from state only. slice_f is sampled in the same cycle slice_x/slice_y are driven; the slice must settle within one clock period.

## Test plan
- AND, WIDTH=32: x=F0F01234, y=0FF0FFFF, op=00, out_ready=1.
  - Required: out_valid exactly 8 cycles after accept; f=00F01234; zero=0; slice_x sequence 4,3,2,1,0,F,0,F.
- ANDN: x=F0F01234, y=0FF0FFFF, op=01.
  - Required: f=F0000000; slice_y sequence 0,0,0,0,F,0,0,F.
- NAND zero flag: x=y=FFFFFFFF, op=10.
  - Required: f=00000000; zero=1.
- NOR: x=0000000F, y=000000F0, op=11.
  - Required: f=FFFFFF00.
- Backpressure and idle behaviour:
  - Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands.
  - Required: out_valid and f stable throughout; in_ready=0; no new accept; in_ready=1 exactly one cycle after out_ready is sampled high.
- Reset mid-operation: drop rst_n while cnt=3.
  - Required: same cycle f=0, busy=0, out_valid=0, in_ready=1.
  - After release, a fresh AND of 12345678 & FFFF0000 yields 12340000.
